// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared constants for the keypad numeric entry stage.
// Holds the scanner key codes and the entry/convert state encoding.
package key_entry_pkg;

    localparam logic [9:0] KEY_DIG_MAX = 10'd9;
    localparam logic [9:0] KEY_BKSP    = 10'd10;
    localparam logic [9:0] KEY_CLR     = 10'd11;
    localparam logic [9:0] KEY_ENT     = 10'd12;

    typedef enum logic {
        ST_ENTRY   = 1'b0,
        ST_CONVERT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_seq_to_bin.sv
// bcd_seq_to_bin: serial BCD-to-binary converter, one digit per cycle.
// Walks the nibbles most significant first; done marks the final step.
import key_entry_pkg::*;

module bcd_seq_to_bin #(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic                clk_M,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic [VAL_W-1:0]    result,
    output logic                done
);

    localparam logic [2:0]       IDX_MAX = 3'(DIGITS - 1);
    localparam logic [VAL_W-1:0] TEN     = VAL_W'(10);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       nib;
    logic [VAL_W-1:0] step;

    // Accumulate one digit: acc*10 + current nibble.
    always_comb begin
        nib    = bcd[4*idx_q +: 4];
        step   = acc_q * TEN + VAL_W'(nib);
        busy   = (state_q == ST_CONVERT);
        done   = busy && (idx_q == 3'd0);
        result = step;
    end

    // Next-state: arm on start, count idx down, return to entry after digit 0.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_ENTRY: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = IDX_MAX;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (idx_q == 3'd0) begin
                    acc_d   = '0;
                    state_d = ST_ENTRY;
                end else begin
                    acc_d = step;
                    idx_d = idx_q - 3'd1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_M) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/key_entry.sv
// key_entry: keypad digit buffer editor with enter-triggered conversion.
// Edge-detects the key strobe, edits the BCD buffer, launches conversion.
import key_entry_pkg::*;

module key_entry #(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic                clk_M,
    input  logic                reset,
    input  logic [9:0]          key_num,
    input  logic                key_flag,
    output logic [4*DIGITS-1:0] bcd,
    output logic [2:0]          digit_cnt,
    output logic [VAL_W-1:0]    value,
    output logic                value_valid,
    output logic                busy
);

    localparam logic [2:0] CNT_MAX = 3'(DIGITS);

    logic                key_flag_q, key_flag_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [VAL_W-1:0]    value_q, value_d;
    logic                valid_q, valid_d;

    logic                ev;
    logic                acc_ev;
    logic                is_dig;
    logic                start;
    logic                conv_busy;
    logic                conv_done;
    logic [VAL_W-1:0]    conv_result;

    bcd_seq_to_bin #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_conv (
        .clk_M  (clk_M),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd_q),
        .busy   (conv_busy),
        .result (conv_result),
        .done   (conv_done)
    );

    // Key decode; events during conversion are dropped.
    always_comb begin
        ev     = key_flag & ~key_flag_q;
        acc_ev = ev & ~conv_busy;
        is_dig = (key_num <= KEY_DIG_MAX);
        start  = acc_ev && (key_num == KEY_ENT) && (cnt_q != 3'd0);
    end

    // Buffer editing and result capture.
    always_comb begin
        key_flag_d = key_flag;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        if (conv_done) begin
            value_d = conv_result;
            valid_d = 1'b1;
            bcd_d   = '0;
            cnt_d   = '0;
        end else if (acc_ev) begin
            unique case (1'b1)
                is_dig: begin
                    if (cnt_q < CNT_MAX) begin
                        bcd_d = (bcd_q << 4) | (4*DIGITS)'(key_num[3:0]);
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                (key_num == KEY_BKSP): begin
                    if (cnt_q != 3'd0) begin
                        bcd_d = bcd_q >> 4;
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                (key_num == KEY_CLR): begin
                    bcd_d = '0;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    // Registers with synchronous reset.
    always_ff @(posedge clk_M) begin
        if (reset) begin
            key_flag_q <= 1'b0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            key_flag_q <= key_flag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
        end
    end

    assign bcd         = bcd_q;
    assign digit_cnt   = cnt_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign busy        = conv_busy;

endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: random and directed stimulus for key_entry.
// A digit-list reference model is compared against the DUT every cycle.
module tb_key_entry;

    localparam int DIGITS = 4;
    localparam int VAL_W  = 14;

    logic                clk_M = 1'b0;
    logic                reset = 1'b1;
    logic [9:0]          key_num = '0;
    logic                key_flag = 1'b0;
    logic [4*DIGITS-1:0] bcd;
    logic [2:0]          digit_cnt;
    logic [VAL_W-1:0]    value;
    logic                value_valid;
    logic                busy;

    key_entry #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) dut (
        .clk_M       (clk_M),
        .reset       (reset),
        .key_num     (key_num),
        .key_flag    (key_flag),
        .bcd         (bcd),
        .digit_cnt   (digit_cnt),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy)
    );

    always #5 clk_M = ~clk_M;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Reference model: entered digits as a list, conversion as a countdown.
    int mq[$];
    int m_pend = 0;
    int m_pval = 0;
    int m_val  = 0;
    bit m_valid = 1'b0;
    bit m_prev  = 1'b0;

    always @(posedge clk_M) begin : mdl
        bit ev;
        int k;
        if (reset) begin
            mq.delete();
            m_pend  = 0;
            m_val   = 0;
            m_valid = 1'b0;
            m_prev  = 1'b0;
        end else begin
            ev      = key_flag && !m_prev;
            m_prev  = key_flag;
            m_valid = 1'b0;
            k       = int'(key_num);
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_val   = m_pval;
                    m_valid = 1'b1;
                    mq.delete();
                end
            end else if (ev) begin
                if (k <= 9) begin
                    if (mq.size() < DIGITS) mq.push_back(k);
                end else if (k == 10) begin
                    if (mq.size() > 0) void'(mq.pop_back());
                end else if (k == 11) begin
                    mq.delete();
                end else if (k == 12 && mq.size() > 0) begin
                    m_pval = 0;
                    foreach (mq[i]) m_pval = m_pval * 10 + mq[i];
                    m_pend = DIGITS;
                end
            end
        end
    end

    function automatic longint m_bcd();
        longint b = 0;
        foreach (mq[i]) b = (b << 4) | longint'(mq[i]);
        return b;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk_M) begin
        if (chk_en) begin
            chk("bcd", bcd, m_bcd());
            chk("digit_cnt", digit_cnt, mq.size());
            chk("value", value, m_val);
            chk("value_valid", value_valid, m_valid);
            chk("busy", busy, m_pend > 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_M);
    endtask

    task automatic press(input int k);
        key_num  = 10'(k);
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
        key_num  = 10'($urandom);
        tick(1);
    endtask

    // Press enter, watch a fixed window, report first-pulse latency and count.
    task automatic enter_wait(output int lat, output int np);
        key_num  = 10'd12;
        key_flag = 1'b1;
        lat = 0;
        np  = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            key_flag = 1'b0;
            if (value_valid) begin
                np++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    initial begin
        int lat, np, hit;
        tick(3);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_bcd", bcd, 0);
        chk("rst_cnt", digit_cnt, 0);
        chk("rst_value", value, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_busy", busy, 0);

        press(1); press(2); press(3);
        chk("bcd_123", bcd, 'h0123);
        chk("cnt_123", digit_cnt, 3);
        enter_wait(lat, np);
        chk("lat_123", lat, 5);
        chk("np_123", np, 1);
        chk("val_123", value, 123);
        chk("bcd_clr_after", bcd, 0);
        chk("cnt_clr_after", digit_cnt, 0);

        press(9); press(8); press(7); press(6); press(5);
        chk("bcd_9876", bcd, 'h9876);
        chk("cnt_full", digit_cnt, 4);
        enter_wait(lat, np);
        chk("val_9876", value, 9876);
        chk("np_9876", np, 1);

        press(4); press(5); press(10); press(7);
        chk("bcd_47", bcd, 'h47);
        enter_wait(lat, np);
        chk("val_47", value, 47);
        press(10);
        chk("bksp0_bcd", bcd, 0);
        chk("bksp0_cnt", digit_cnt, 0);
        press(3); press(11);
        enter_wait(lat, np);
        chk("empty_enter_np", np, 0);
        chk("empty_enter_val", value, 47);

        key_num  = 10'd5;
        key_flag = 1'b1;
        tick(10);
        key_flag = 1'b0;
        tick(1);
        chk("hold_cnt", digit_cnt, 1);
        chk("hold_bcd", bcd, 5);
        press(13); press(15);
        chk("ign_bcd", bcd, 5);
        chk("ign_cnt", digit_cnt, 1);
        press(11);

        press(1); press(2);
        key_num  = 10'd12;
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
        tick(1);
        key_num  = 10'd9;
        key_flag = 1'b1;
        tick(1);
        chk("busy_mid", busy, 1);
        key_flag = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (value_valid) begin
                hit = 1;
                key_num  = 10'd6;
                key_flag = 1'b1;
                tick(1);
                key_flag = 1'b0;
                chk("val_12", value, 12);
                chk("bcd_after_pulse", bcd, 6);
                break;
            end
        end
        chk("pulse_12_seen", hit, 1);
        press(11);

        press(7); press(8);
        key_num  = 10'd12;
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mrst_bcd", bcd, 0);
        chk("mrst_cnt", digit_cnt, 0);
        chk("mrst_value", value, 0);
        chk("mrst_busy", busy, 0);
        np = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (value_valid) np++;
        end
        chk("mrst_no_pulse", np, 0);
        press(4); press(2);
        enter_wait(lat, np);
        chk("val_42", value, 42);
        chk("np_42", np, 1);

        for (int it = 0; it < 400; it++) begin
            int r, k;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset = 1'b1;
                tick(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end else begin
                if (r < 55) k = int'($urandom_range(0, 9));
                else k = int'($urandom_range(10, 15));
                key_num  = 10'(k);
                key_flag = 1'b1;
                tick(int'($urandom_range(1, 3)));
                key_flag = 1'b0;
                key_num  = 10'($urandom);
                tick(int'($urandom_range(0, 3)));
            end
        end

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
